// File: rtl/osd_mam_bb_req_gen.sv
// MAM word-stream front-end: parses header/address words into a blackbone
// request, then passes write data or read data straight through.
module osd_mam_bb_req_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_we,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_burst,
  output logic [12:0]           req_beats,
  output logic                  write_valid,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [1:0]            write_strb,
  input  logic                  write_ready,
  input  logic                  read_valid,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_ready,
  output logic                  busy,
  output logic                  err
);

  localparam int AW = ADDR_WIDTH / 16;
  localparam int CW = (AW > 1) ? $clog2(AW) : 1;

  typedef enum logic [2:0] {S_HDR, S_ADDR, S_REQ, S_WDATA, S_RDATA} state_t;

  state_t        state;
  logic [CW-1:0] addr_cnt;
  logic [12:0]   beats_left;

  logic        hdr_we;
  logic        hdr_burst;
  logic [12:0] hdr_beats;
  logic [12:0] hdr_len;

  assign hdr_we    = in_data[15];
  assign hdr_burst = in_data[14];
  assign hdr_beats = in_data[12:0];
  assign hdr_len   = hdr_burst ? hdr_beats : 13'd1;

  assign write_data = in_data;
  assign out_data   = read_data;
  assign write_strb = 2'b11;

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    write_valid = 1'b0;
    read_ready  = 1'b0;
    case (state)
      S_HDR, S_ADDR: in_ready = 1'b1;
      S_WDATA: begin
        write_valid = in_valid;
        in_ready    = write_ready;
      end
      S_RDATA: begin
        out_valid  = read_valid;
        read_ready = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_HDR;
      addr_cnt   <= '0;
      beats_left <= '0;
      req_valid  <= 1'b0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_burst  <= 1'b0;
      req_beats  <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_HDR: begin
          if (in_valid) begin
            // A zero-length burst is dropped here so the beat counter never wraps.
            if (hdr_burst && hdr_beats == '0) begin
              err <= 1'b1;
            end else begin
              req_we     <= hdr_we;
              req_burst  <= hdr_burst;
              req_beats  <= hdr_len;
              beats_left <= hdr_len;
              addr_cnt   <= '0;
              busy       <= 1'b1;
              state      <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (in_valid) begin
            req_addr <= (req_addr << 16) | ADDR_WIDTH'(in_data);
            if (addr_cnt == CW'(AW - 1)) begin
              req_valid <= 1'b1;
              state     <= S_REQ;
            end else begin
              addr_cnt <= addr_cnt + 1'b1;
            end
          end
        end
        S_REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= req_we ? S_WDATA : S_RDATA;
          end
        end
        S_WDATA: begin
          if (in_valid && write_ready) begin
            beats_left <= beats_left - 1'b1;
            if (beats_left == 13'd1) begin
              state <= S_HDR;
              busy  <= 1'b0;
            end
          end
        end
        S_RDATA: begin
          if (read_valid && out_ready) begin
            beats_left <= beats_left - 1'b1;
            if (beats_left == 13'd1) begin
              state <= S_HDR;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_HDR;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osd_mam_bb_req_gen.sv
// Directed and randomized transactions for osd_mam_bb_req_gen, checked against
// a transaction-level model derived from the header word.
module tb_osd_mam_bb_req_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic        req_burst;
  logic [12:0] req_beats;
  logic        write_valid;
  logic [15:0] write_data;
  logic [1:0]  write_strb;
  logic        write_ready;
  logic        read_valid;
  logic [15:0] read_data;
  logic        read_ready;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [15:0] wq[$];
  logic [15:0] rq[$];

  always #5 clk_i = ~clk_i;

  osd_mam_bb_req_gen #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
    .write_valid(write_valid), .write_data(write_data), .write_strb(write_strb),
    .write_ready(write_ready), .read_valid(read_valid), .read_data(read_data),
    .read_ready(read_ready), .busy(busy), .err(err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put_word(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk_i);
    in_valid = 1'b1;
    in_data  = w;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk("in_accept", in_ready, 1'b1);
    @(posedge clk_i);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk_i);
    #1;
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_req_valid"}, req_valid, 1'b0);
    chk({tag, "_wvalid"}, write_valid, 1'b0);
    chk({tag, "_ovalid"}, out_valid, 1'b0);
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic burst,
                        input logic [12:0] beats, input int stall);
    @(negedge clk_i);
    #1;
    chk("req_latency", req_valid, 1'b1);
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) begin
        @(negedge clk_i);
        #1;
      end
      chk("req_valid", req_valid, 1'b1);
      chk("req_we", req_we, we);
      chk("req_addr", req_addr, addr);
      chk("req_burst", req_burst, burst);
      chk("req_beats", req_beats, beats);
      chk("req_in_ready", in_ready, 1'b0);
      chk("req_busy", busy, 1'b1);
    end
    req_ready = 1'b1;
    @(posedge clk_i);
    #1;
    req_ready = 1'b0;
  endtask

  // mode 0: always ready, 1: ready toggles 1/0, 2: random valid/ready
  task automatic do_write(input int mode);
    int  idx, cyc;
    bit  tog, iv, wr;
    idx = 0; cyc = 0; tog = 1'b1;
    while (idx < wq.size() && cyc < 300) begin
      @(negedge clk_i);
      iv = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      in_valid    = iv;
      in_data     = iv ? wq[idx] : 16'($urandom);
      write_ready = wr;
      #1;
      chk("wr_valid", write_valid, iv);
      chk("wr_in_ready", in_ready, wr);
      chk("wr_busy", busy, 1'b1);
      if (iv) begin
        chk("wr_data", write_data, wq[idx]);
        chk("wr_strb", write_strb, 2'b11);
      end
      if (iv && wr) idx++;
      cyc++;
    end
    chk("wr_count", idx, wq.size());
    if (mode == 0) chk("wr_throughput", cyc, wq.size());
    @(posedge clk_i);
    #1;
    in_valid    = 1'b0;
    write_ready = 1'b0;
  endtask

  task automatic do_read(input int mode);
    int idx, cyc;
    bit rv, ordy;
    idx = 0; cyc = 0;
    while (idx < rq.size() && cyc < 300) begin
      @(negedge clk_i);
      rv   = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ordy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      read_valid = rv;
      read_data  = rv ? rq[idx] : 16'($urandom);
      out_ready  = ordy;
      #1;
      chk("rd_out_valid", out_valid, rv);
      chk("rd_read_ready", read_ready, ordy);
      chk("rd_in_ready", in_ready, 1'b0);
      if (rv) chk("rd_data", out_data, rq[idx]);
      if (rv && ordy) idx++;
      cyc++;
    end
    chk("rd_count", idx, rq.size());
    @(posedge clk_i);
    #1;
    read_valid = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic run_txn(input logic [15:0] hdr, input logic [31:0] addr,
                         input int mode, input int stall, input bit fill);
    logic        we, burst;
    logic [12:0] beats;
    we    = hdr[15];
    burst = hdr[14];
    beats = burst ? hdr[12:0] : 13'd1;
    if (burst && beats == 0) begin
      put_word(hdr);
      @(negedge clk_i);
      #1;
      chk("bad_err_pulse", err, 1'b1);
      chk("bad_no_req", req_valid, 1'b0);
      chk("bad_busy", busy, 1'b0);
      @(negedge clk_i);
      #1;
      chk("bad_err_clear", err, 1'b0);
      chk("bad_no_req2", req_valid, 1'b0);
      return;
    end
    if (fill) begin
      wq.delete();
      rq.delete();
      for (int i = 0; i < int'(beats); i++) begin
        wq.push_back(16'($urandom));
        rq.push_back(16'($urandom));
      end
    end
    put_word(hdr);
    put_word(addr[31:16]);
    put_word(addr[15:0]);
    do_req(we, addr, burst, beats, stall);
    if (we) do_write(mode);
    else    do_read(mode);
    check_idle("post_txn");
  endtask

  initial begin
    logic [15:0] hdr;
    logic        we, burst;
    rst_ni = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; req_ready = 1'b0;
    write_ready = 1'b0; read_valid = 1'b0; read_data = '0;

    // Reset state
    #12;
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_req_we", req_we, 1'b0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_req_burst", req_burst, 1'b0);
    chk("rst_req_beats", req_beats, 13'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_wvalid", write_valid, 1'b0);
    chk("rst_read_ready", read_ready, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check_idle("after_rst");

    // Single write
    wq.delete(); wq.push_back(16'hBEEF);
    run_txn(16'h8000, 32'h1234_5678, 0, 0, 1'b0);

    // Burst read, 3 beats
    rq.delete(); rq.push_back(16'h00A1); rq.push_back(16'h00A2); rq.push_back(16'h00A3);
    run_txn(16'h4003, 32'h0000_0100, 0, 0, 1'b0);

    // Burst write with toggling write_ready
    run_txn(16'hC004, 32'h0000_0040, 1, 0, 1'b1);

    // Malformed header, then a normal one; reserved bit set must be ignored
    run_txn(16'h4000, 32'h0, 0, 0, 1'b1);
    run_txn(16'h2000, 32'hCAFE_0002, 0, 0, 1'b1);

    // req_ready stall
    run_txn(16'hC002, 32'hDEAD_BEEF, 0, 5, 1'b1);

    // Reset mid-burst of an 8-beat write
    put_word(16'hC008);
    put_word(16'h0000);
    put_word(16'h0080);
    do_req(1'b1, 32'h0000_0080, 1'b1, 13'd8, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      in_valid = 1'b1; in_data = 16'(16'h1000 + i); write_ready = 1'b1;
    end
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("amid_req_valid", req_valid, 1'b0);
    chk("amid_req_we", req_we, 1'b0);
    chk("amid_req_addr", req_addr, 32'h0);
    chk("amid_req_burst", req_burst, 1'b0);
    chk("amid_req_beats", req_beats, 13'h0);
    chk("amid_busy", busy, 1'b0);
    chk("amid_err", err, 1'b0);
    chk("amid_wvalid", write_valid, 1'b0);
    chk("amid_out_valid", out_valid, 1'b0);
    chk("amid_read_ready", read_ready, 1'b0);
    in_valid = 1'b0; write_ready = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    check_idle("after_amid_rst");
    run_txn(16'h4002, 32'h0BAD_F00D, 0, 0, 1'b1);

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      we    = 1'($urandom_range(0, 1));
      burst = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        hdr = {we, 1'b1, 1'($urandom_range(0, 1)), 13'd0};
      else if (burst)
        hdr = {we, 1'b1, 1'($urandom_range(0, 1)), 13'($urandom_range(1, 6))};
      else
        hdr = {we, 1'b0, 1'($urandom_range(0, 1)), 13'($urandom)};
      run_txn(hdr, $urandom, 2, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
